mix_pipe: RTL and testbench

Parametrised, pipelined successor to the c17-style `mix` benchmark core. It computes WIDTH independent lanes of the six-NAND c17 network plus the G21 XOR term, behind a valid/ready elastic pipeline of DEPTH register stages. A MISR signature and a transaction counter over accepted outputs make it a sequential netlist fixture for graph and unrolling tests. It sits as a standalone benchmark module and may be instantiated multiple times.

---
 rtl/mix_pipe.sv | 129 ++++++++++++
 tb/tb_mix_pipe.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mix_pipe : WIDTH-lane c17 NAND network + G21 XOR behind a DEPTH-stage
//            valid/ready pipeline, with MISR signature and saturating count.
// rev 1.0
// ---------------------------------------------------------------------------
module mix_pipe #(
  parameter int               WIDTH = 4,
  parameter int               DEPTH = 2,
  parameter int               SIG_W = 8,
  parameter logic [SIG_W-1:0] POLY  = 8'h1D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] g1,
  input  logic [WIDTH-1:0] g2,
  input  logic [WIDTH-1:0] g3,
  input  logic [WIDTH-1:0] g4,
  input  logic [WIDTH-1:0] g5,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] g16,
  output logic [WIDTH-1:0] g17,
  output logic [WIDTH-1:0] g21,
  output logic [SIG_W-1:0] sig,
  output logic [15:0]      count
);

  localparam int DW  = 3 * WIDTH;
  localparam int NSL = (DW + SIG_W - 1) / SIG_W;
  localparam int PW  = NSL * SIG_W;

  logic [WIDTH-1:0] n8, n9, n12, n15, n16, n17, n21;
  logic [DW-1:0]    net;

  always_comb begin
    n8  = ~(g1 & g3);
    n9  = ~(g3 & g4);
    n12 = ~(g2 & n9);
    n15 = ~(n9 & g5);
    n16 = ~(n8 & n12);
    n17 = ~(n12 & n15);
    n21 = n17 ^ (g1 & g5);
    net = {n21, n17, n16};
  end

  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [DEPTH-1:0][DW-1:0] data_q, data_d;
  logic [DEPTH-1:0]         load, move;
  logic                     accept, retire;

  // Ready chain resolved from the output end back to stage 0 in one cycle.
  always_comb begin
    load = '0;
    move = '0;
    move[DEPTH-1] = valid_q[DEPTH-1] & out_ready;
    load[DEPTH-1] = ~valid_q[DEPTH-1] | move[DEPTH-1];
    for (int k = DEPTH - 2; k >= 0; k--) begin
      move[k] = valid_q[k] & load[k+1];
      load[k] = ~valid_q[k] | move[k];
    end
  end

  assign in_ready = rst_n & load[0];
  assign accept   = in_valid & in_ready;
  assign retire   = valid_q[DEPTH-1] & out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load[0]) begin
      valid_d[0] = accept;
      if (accept) data_d[0] = net;
    end
    for (int k = 1; k < DEPTH; k++) begin
      if (load[k]) begin
        valid_d[k] = valid_q[k-1];
        if (valid_q[k-1]) data_d[k] = data_q[k-1];
      end
    end
  end

  logic [SIG_W-1:0] sig_q, sig_d, fold;
  logic [15:0]      count_q, count_d;
  logic [PW-1:0]    pad;

  always_comb begin
    pad          = '0;
    pad[DW-1:0]  = data_q[DEPTH-1];
    fold         = '0;
    for (int s = 0; s < NSL; s++) fold ^= pad[s*SIG_W +: SIG_W];
    sig_d   = sig_q;
    count_d = count_q;
    // Clear takes priority: a word retiring in the same cycle is dropped.
    if (clear) begin
      sig_d   = '0;
      count_d = '0;
    end else if (retire) begin
      sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ fold;
      if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
      sig_q   <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sig_q   <= sig_d;
      count_q <= count_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign g16       = data_q[DEPTH-1][WIDTH-1:0];
  assign g17       = data_q[DEPTH-1][2*WIDTH-1:WIDTH];
  assign g21       = data_q[DEPTH-1][3*WIDTH-1:2*WIDTH];
  assign sig       = sig_q;
  assign count     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_mix_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mix_pipe : randomized and directed bench for mix_pipe against a lane-level
//               reference model with expected-word queue, MISR and counter.
// rev 1.0
// ---------------------------------------------------------------------------
module tb_mix_pipe;

  localparam int          W    = 4;
  localparam int          SW   = 8;
  localparam int unsigned MASK = (1 << SW) - 1;
  localparam int unsigned PLY  = 32'h1D;

  logic         clk = 1'b0;
  logic         rst_n, clear, in_valid, out_ready;
  logic         in_ready, out_valid;
  logic [W-1:0] g1, g2, g3, g4, g5, g16, g17, g21;
  logic [SW-1:0] sig;
  logic [15:0]  count;

  mix_pipe #(.WIDTH(W), .DEPTH(2), .SIG_W(SW), .POLY(8'h1D)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .g1(g1), .g2(g2), .g3(g3), .g4(g4), .g5(g5),
    .out_valid(out_valid), .out_ready(out_ready),
    .g16(g16), .g17(g17), .g21(g21),
    .sig(sig), .count(count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3*W-1:0] exp_q[$];
  int unsigned    m_sig = 0;
  int unsigned    m_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Per-lane evaluation of the c17 network plus the XOR term.
  function automatic logic [3*W-1:0] ref_word(input logic [W-1:0] a1, a2, a3, a4, a5);
    logic [W-1:0] o16, o17, o21;
    bit n8, n9, n12, n15;
    for (int i = 0; i < W; i++) begin
      n8     = !(a1[i] && a3[i]);
      n9     = !(a3[i] && a4[i]);
      n12    = !(a2[i] && n9);
      n15    = !(n9 && a5[i]);
      o16[i] = !(n8 && n12);
      o17[i] = !(n12 && n15);
      o21[i] = o17[i] ^ (a1[i] && a5[i]);
    end
    return {o21, o17, o16};
  endfunction

  function automatic int unsigned misr(input int unsigned s, input int unsigned d);
    int unsigned f = 0;
    for (int k = 0; k < 3 * W; k += SW) f ^= (d >> k) & MASK;
    return ((s << 1) & MASK) ^ (((s >> (SW - 1)) & 1) != 0 ? PLY : 0) ^ f;
  endfunction

  // One clock: sample mid-cycle, advance the model at the edge, return at edge+1.
  task automatic cycle();
    logic           acc, ret;
    logic [3*W-1:0] w_in, w_out;
    #2;
    acc   = in_valid & in_ready;
    ret   = out_valid & out_ready;
    w_in  = ref_word(g1, g2, g3, g4, g5);
    w_out = '0;
    if (rst_n) begin
      check("sig", 32'(sig), m_sig);
      check("count", 32'(count), m_cnt);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          w_out = exp_q[0];
          check("g16", 32'(g16), 32'(w_out[W-1:0]));
          check("g17", 32'(g17), 32'(w_out[2*W-1:W]));
          check("g21", 32'(g21), 32'(w_out[3*W-1:2*W]));
          if (ret) void'(exp_q.pop_front());
        end
      end
    end
    @(posedge clk);
    if (!rst_n) begin
      exp_q.delete();
      m_sig = 0;
      m_cnt = 0;
    end else begin
      if (acc) exp_q.push_back(w_in);
      if (clear) begin
        m_sig = 0;
        m_cnt = 0;
      end else if (ret) begin
        m_sig = misr(m_sig, 32'(w_out));
        if (m_cnt != 32'hFFFF) m_cnt++;
      end
    end
    #1;
  endtask

  task automatic drive(input logic [W-1:0] a1, a2, a3, a4, a5);
    g1 = a1; g2 = a2; g3 = a3; g4 = a4; g5 = a5;
  endtask

  task automatic send_and_expect(input logic [W-1:0] a1, a2, a3, a4, a5,
                                 input logic [W-1:0] e16, e17, e21);
    drive(a1, a2, a3, a4, a5);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    check("lat_early_ov", 32'(out_valid), 32'd0);
    cycle();
    check("lat_ov", 32'(out_valid), 32'd1);
    check("fn_g16", 32'(g16), 32'(e16));
    check("fn_g17", 32'(g17), 32'(e17));
    check("fn_g21", 32'(g21), 32'(e21));
    cycle();
  endtask

  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((out_valid || exp_q.size() != 0) && n < 20) begin
      cycle();
      n++;
    end
    check("drain_timeout", 32'(n < 20), 32'd1);
  endtask

  initial begin
    int wi, c, acc_n;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    drive('1, '1, '1, '1, '1);
    @(posedge clk); #1;

    // Reset held with in_valid high
    for (int i = 0; i < 3; i++) begin
      check("rst_in_ready", 32'(in_ready), 32'd0);
      cycle();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_sig", 32'(sig), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_g", {20'd0, g21, g17, g16}, 32'd0);
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);

    // Functional vectors and MISR golden values
    send_and_expect(4'hF, 4'hF, 4'hF, 4'h0, 4'hF, 4'hF, 4'hF, 4'h0);
    check("misr1_sig", 32'(sig), 32'hFF);
    send_and_expect(4'hF, 4'hF, 4'hF, 4'h0, 4'hF, 4'hF, 4'hF, 4'h0);
    check("misr2_sig", 32'(sig), 32'h1C);
    check("misr2_count", 32'(count), 32'd2);
    send_and_expect(4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'hF);
    send_and_expect(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

    clear = 1'b1;
    cycle();
    clear = 1'b0;

    // Backpressure: six distinct words, output stalled for four cycles
    wi = 0; c = 0;
    while (wi < 6 && c < 50) begin
      out_ready = (c >= 4);
      in_valid  = 1'b1;
      drive(W'(wi), W'(wi * 3 + 1), W'(~wi), W'(wi * 5 + 2), W'(wi + 9));
      #1;
      if (c == 2) check("bp_in_ready", 32'(in_ready), 32'd0);
      if (in_ready) wi++;
      cycle();
      c++;
    end
    check("bp_timeout", 32'(wi), 32'd6);
    drain();
    check("bp_count", 32'(count), 32'd6);

    // Clear colliding with a retire
    drive(4'h5, 4'hA, 4'h3, 4'hC, 4'h9);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    check("clr_pre_ov", 32'(out_valid), 32'd1);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    check("clr_sig", 32'(sig), 32'd0);
    check("clr_count", 32'(count), 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      clear     = ($urandom % 50) == 0;
      drive(W'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom));
      cycle();
    end
    clear = 1'b0;
    drain();

    // Saturation of the counter
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    acc_n = 0; c = 0;
    out_ready = 1'b1;
    while (acc_n < 65540 && c < 70000) begin
      in_valid = 1'b1;
      drive(W'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom));
      #1;
      if (in_ready) acc_n++;
      cycle();
      c++;
    end
    check("sat_stream_timeout", 32'(acc_n), 32'd65540);
    drain();
    check("sat_count", 32'(count), 32'hFFFF);

    // Mid-operation reset with two words in flight
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      drive(W'(i + 3), 4'hF, 4'hF, 4'h1, 4'hE);
      cycle();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    check("mrst_count", 32'(count), 32'd0);
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_sig", 32'(sig), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("mrst_no_emit", 32'(out_valid), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
